avalon_mm_slave_mem: RTL and testbench
======================================

// Module: avalon_mm_slave_mem
// PURPOSE
//  Avalon-MM slave memory: byte-enabled, word-addressed RAM behind a pipelined, burst-capable slave port.
//  Target for the Avalon-MM master VIP; connects directly to avalon_s_if signals (master drives cmd, slave returns data).
//  Supports single and burst reads/writes, readdatavalid return, waitrequest flow control.
// PARAMETERS
//  DATA_W   32  data bus width in bits (multiple of 8)
//  ADDR_W   10  word address width; memory depth = 2**ADDR_W words
//  BURST_W  4   burstcount width; legal burst length 1..2**BURST_W-1
// PORTS
//  clk                 in   1          single clock; all logic on rising edge
//  reset               in   1          synchronous, active-high reset
//  address             in   ADDR_W     word address (first beat of burst)
//  byteenable          in   DATA_W/8   per-byte write enable; ignored for reads
//  chipselect          in   1          transfer qualifier
//  read                in   1          read request
//  write               in   1          write request
//  writedata           in   DATA_W     write data
//  burstcount          in   BURST_W    beats in burst; sampled on first beat only
//  beginbursttransfer  in   1          informational; not required for operation
//  readdata            out  DATA_W     read data, valid when readdatavalid=1
//  waitrequest         out  1          1 = command not accepted this cycle
//  readdatavalid       out  1          1 = readdata holds a returned beat
// BEHAVIOUR
//  Reset (sync, high): state IDLE; waitrequest=1 during reset, 0 first cycle after; readdatavalid=0,
//   readdata=0; counters 0; memory contents NOT cleared. Reset mid-burst aborts burst, no further beats.
//  Accept = chipselect & (read|write) & ~waitrequest at rising edge. read&write together: write wins.
//  burstcount=0 treated as 1. Burst addresses increment by 1 per beat, wrap modulo 2**ADDR_W.
//  FSM IDLE / WR_BURST / RD_BURST:
//   IDLE: accepted write -> mem[addr] updated per byteenable at that edge; burstcount>1 -> WR_BURST,
//    remaining = burstcount-1, next addr = addr+1. Accepted read -> RD_BURST, N = burstcount.
//   WR_BURST: each accepted write beat writes mem[next addr] (address/burstcount inputs ignored);
//    remaining==1 on accept -> IDLE. waitrequest stays 0. read during WR_BURST ignored (protocol error).
//   RD_BURST: read accepted at edge T -> waitrequest=1 cycles T+1..T+N; readdatavalid=1 and
//    readdata=mem[addr+k] in cycle T+1+k, k=0..N-1, back-to-back, no gaps; IDLE and waitrequest=0 at T+N+1.
//  Latency: single read data 1 cycle after acceptance. Write-then-read same word returns new data.
//  readdata holds last beat value when readdatavalid=0 (not required to be zero).
//  Unwritten locations return X in simulation; no init file.
// STRUCTURE
//  Package avalon_mm_pkg: DATA_W/ADDR_W/BURST_W defaults, BE_W=DATA_W/8, state enum
//   {IDLE, WR_BURST, RD_BURST}.
//  Sub-module avalon_mm_bram: single-port sync RAM, byte-enable write, 1-cycle registered read.
//  Top: FSM, beat counter, address counter, waitrequest/readdatavalid registers.
// TESTING
//  Single write 0xDEADBEEF @0x010 be=1111, read @0x010 -> readdatavalid 1 cycle after accept, data 0xDEADBEEF.
//  Byte-enable: write 0x11223344 @0x020, then 0xAABBCCDD be=0101 -> readback 0x11BB33DD.
//  Write burst 4 @0x100 data 1,2,3,4; read burst 4 @0x100 -> 4 consecutive valid beats 1,2,3,4;
//   waitrequest high T+1..T+4.
//  Wrap: burst write 3 @0x3FF (ADDR_W=10) -> words 0x3FF,0x000,0x001 written; read back confirms.
//  burstcount=0 read @0x010 -> exactly one beat; read&write together @0x030 -> write performed, no readdatavalid.
//  Reset asserted mid read burst (after beat 2 of 4) -> readdatavalid=0 next cycle, waitrequest=1 in reset,
//   0 after; memory retains data.

Source files
------------

// File: rtl/avalon_mm_pkg.sv
// Shared defaults and state type for the Avalon-MM slave memory.
package avalon_mm_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int BURST_W = 4;
    localparam int BE_W    = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

endpackage

// File: rtl/avalon_mm_bram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module avalon_mm_bram #(
    parameter int DATA_W = avalon_mm_pkg::DATA_W,
    parameter int ADDR_W = avalon_mm_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; the array itself is never cleared, so contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read; output holds its last value whenever no read is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/avalon_mm_slave_mem.sv
// Avalon-MM burst-capable slave port in front of a byte-enabled word RAM.
module avalon_mm_slave_mem #(
    parameter int DATA_W  = avalon_mm_pkg::DATA_W,
    parameter int ADDR_W  = avalon_mm_pkg::ADDR_W,
    parameter int BURST_W = avalon_mm_pkg::BURST_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [BURST_W-1:0]    burstcount,
    input  logic                  beginbursttransfer,
    output logic [DATA_W-1:0]     readdata,
    output logic                  waitrequest,
    output logic                  readdatavalid
);

    import avalon_mm_pkg::*;

    state_t               state;
    state_t               next_state;
    logic [BURST_W-1:0]   beat_cnt;
    logic [BURST_W-1:0]   beat_cnt_next;
    logic [ADDR_W-1:0]    addr_cnt;
    logic [ADDR_W-1:0]    addr_cnt_next;
    logic                 rd_valid;
    logic                 rd_valid_next;
    logic                 accept;
    logic [BURST_W-1:0]   burst_len;
    logic                 ram_we;
    logic                 ram_re;
    logic [ADDR_W-1:0]    ram_addr;
    logic                 unused_begin;

    // beginbursttransfer carries no information this slave needs
    assign unused_begin  = beginbursttransfer;

    // Stalled while in reset and for the whole read-return window
    assign waitrequest   = reset | (state == RD_BURST);
    assign accept        = chipselect & (read | write) & ~waitrequest;
    assign burst_len     = (burstcount == '0) ? BURST_W'(1) : burstcount;
    assign readdatavalid = rd_valid;

    // State, beat/address counters and readdatavalid register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_cnt <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= next_state;
            beat_cnt <= beat_cnt_next;
            addr_cnt <= addr_cnt_next;
            rd_valid <= rd_valid_next;
        end
    end

    // Next-state logic, counter updates and RAM port steering (write wins over read)
    always_comb begin
        next_state    = state;
        beat_cnt_next = beat_cnt;
        addr_cnt_next = addr_cnt;
        rd_valid_next = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_addr      = addr_cnt;
        case (state)
            IDLE: begin
                if (accept && write) begin
                    ram_we        = 1'b1;
                    ram_addr      = address;
                    addr_cnt_next = address + ADDR_W'(1);
                    beat_cnt_next = burst_len - BURST_W'(1);
                    if (burst_len > BURST_W'(1)) begin
                        next_state = WR_BURST;
                    end
                end else if (accept) begin
                    ram_re        = 1'b1;
                    ram_addr      = address;
                    addr_cnt_next = address + ADDR_W'(1);
                    beat_cnt_next = burst_len - BURST_W'(1);
                    rd_valid_next = 1'b1;
                    next_state    = RD_BURST;
                end
            end
            WR_BURST: begin
                if (accept && write) begin
                    ram_we        = 1'b1;
                    addr_cnt_next = addr_cnt + ADDR_W'(1);
                    beat_cnt_next = beat_cnt - BURST_W'(1);
                    if (beat_cnt == BURST_W'(1)) begin
                        next_state = IDLE;
                    end
                end
            end
            RD_BURST: begin
                if (beat_cnt == '0) begin
                    next_state = IDLE;
                end else begin
                    ram_re        = 1'b1;
                    addr_cnt_next = addr_cnt + ADDR_W'(1);
                    beat_cnt_next = beat_cnt - BURST_W'(1);
                    rd_valid_next = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    avalon_mm_bram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .reset (reset),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (byteenable),
        .wdata (writedata),
        .re    (ram_re),
        .rdata (readdata)
    );

endmodule

// File: tb/tb_avalon_mm_slave_mem.sv
// Self-checking bench for avalon_mm_slave_mem against a word-array reference model.
module tb_avalon_mm_slave_mem;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int BURST_W = 4;
    localparam int BE_W    = DATA_W / 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int REGION  = 'h200;
    localparam int REGSZ   = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ADDR_W-1:0]    address;
    logic [BE_W-1:0]      byteenable;
    logic                 chipselect;
    logic                 read;
    logic                 write;
    logic [DATA_W-1:0]    writedata;
    logic [BURST_W-1:0]   burstcount;
    logic                 beginbursttransfer;
    logic [DATA_W-1:0]    readdata;
    logic                 waitrequest;
    logic                 readdatavalid;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];

    avalon_mm_slave_mem #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .address            (address),
        .byteenable         (byteenable),
        .chipselect         (chipselect),
        .read               (read),
        .write              (write),
        .writedata          (writedata),
        .burstcount         (burstcount),
        .beginbursttransfer (beginbursttransfer),
        .readdata           (readdata),
        .waitrequest        (waitrequest),
        .readdatavalid      (readdatavalid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [DATA_W-1:0] observed,
                                input logic [DATA_W-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_idle();
        chipselect         = 1'b0;
        read               = 1'b0;
        write              = 1'b0;
        beginbursttransfer = 1'b0;
    endtask

    task automatic model_write(input int addr, input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) ref_mem[addr % DEPTH][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Burst write of n beats; later beats carry junk address/burstcount that must be ignored
    task automatic write_burst(input int addr, input int n, input logic [BE_W-1:0] be,
                               input bit rand_data, input logic [DATA_W-1:0] base);
        for (int k = 0; k < n; k++) begin
            logic [DATA_W-1:0] d;
            d = rand_data ? DATA_W'($urandom) : base + DATA_W'(k);
            chipselect         = 1'b1;
            write              = 1'b1;
            read               = 1'b0;
            address            = (k == 0) ? ADDR_W'(addr) : ADDR_W'($urandom);
            burstcount         = (k == 0) ? BURST_W'(n) : BURST_W'($urandom);
            byteenable         = be;
            writedata          = d;
            beginbursttransfer = (k == 0);
            check_output("wr_waitrequest", DATA_W'(waitrequest), '0);
            next_cycle();
            model_write(addr + k, be, d);
        end
        apply_idle();
    endtask

    // Burst read: beats must appear in cycles T+1..T+N with waitrequest high, then idle
    task automatic read_burst(input int addr, input int bc, input string tag);
        int n;
        n = (bc == 0) ? 1 : bc;
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = ADDR_W'(addr);
        burstcount = BURST_W'(bc);
        check_output($sformatf("%s_accept_wait", tag), DATA_W'(waitrequest), '0);
        next_cycle();
        apply_idle();
        address    = ADDR_W'($urandom);
        burstcount = BURST_W'($urandom);
        for (int k = 0; k < n; k++) begin
            check_output($sformatf("%s_rdv%0d", tag, k), DATA_W'(readdatavalid), 1);
            check_output($sformatf("%s_wait%0d", tag, k), DATA_W'(waitrequest), 1);
            check_output($sformatf("%s_data%0d", tag, k), readdata, ref_mem[(addr + k) % DEPTH]);
            next_cycle();
        end
        check_output($sformatf("%s_rdv_end", tag), DATA_W'(readdatavalid), '0);
        check_output($sformatf("%s_wait_end", tag), DATA_W'(waitrequest), '0);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        byteenable = '1;
        writedata  = '0;
        burstcount = '0;
        apply_idle();
        $display("[TB] reset");
        next_cycle();
        next_cycle();
        check_output("rst_wait", DATA_W'(waitrequest), 1);
        check_output("rst_rdv", DATA_W'(readdatavalid), '0);
        check_output("rst_rdata", readdata, '0);
        reset = 1'b0;
        #1;
        check_output("post_rst_wait", DATA_W'(waitrequest), '0);

        $display("[TB] single write/read");
        write_burst('h010, 1, 4'b1111, 1'b0, 32'hDEADBEEF);
        read_burst('h010, 1, "single");
        check_output("single_hold", readdata, 32'hDEADBEEF);

        $display("[TB] byte enables");
        write_burst('h020, 1, 4'b1111, 1'b0, 32'h11223344);
        write_burst('h020, 1, 4'b0101, 1'b0, 32'hAABBCCDD);
        read_burst('h020, 1, "be");
        check_output("be_hold", readdata, 32'h11BB33DD);

        $display("[TB] burst 4");
        write_burst('h100, 4, 4'b1111, 1'b0, 32'd1);
        read_burst('h100, 4, "burst4");

        $display("[TB] wrap");
        write_burst('h3FF, 3, 4'b1111, 1'b0, 32'hA0);
        read_burst('h3FF, 3, "wrap");
        read_burst('h000, 1, "wrap0");
        check_output("wrap0_hold", readdata, 32'hA1);

        $display("[TB] burstcount zero");
        read_burst('h010, 0, "bc0");

        $display("[TB] read and write together");
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b1;
        address    = ADDR_W'('h030);
        burstcount = BURST_W'(1);
        byteenable = 4'b1111;
        writedata  = 32'hC0FFEE30;
        check_output("rw_accept_wait", DATA_W'(waitrequest), '0);
        next_cycle();
        model_write('h030, 4'b1111, 32'hC0FFEE30);
        apply_idle();
        check_output("rw_no_rdv", DATA_W'(readdatavalid), '0);
        check_output("rw_wait", DATA_W'(waitrequest), '0);
        read_burst('h030, 1, "rw_read");

        $display("[TB] reset during read burst");
        chipselect = 1'b1;
        read       = 1'b1;
        address    = ADDR_W'('h100);
        burstcount = BURST_W'(4);
        next_cycle();
        apply_idle();
        check_output("abort_beat1", readdata, 32'd1);
        next_cycle();
        check_output("abort_beat2", readdata, 32'd2);
        check_output("abort_rdv2", DATA_W'(readdatavalid), 1);
        reset = 1'b1;
        #1;
        check_output("abort_wait_in_rst", DATA_W'(waitrequest), 1);
        next_cycle();
        check_output("abort_rdv", DATA_W'(readdatavalid), '0);
        check_output("abort_wait_rst", DATA_W'(waitrequest), 1);
        check_output("abort_rdata", readdata, '0);
        reset = 1'b0;
        #1;
        check_output("abort_wait_after", DATA_W'(waitrequest), '0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check_output("abort_no_beats", DATA_W'(readdatavalid), '0);
        end
        read_burst('h100, 4, "retained");

        $display("[TB] randomized traffic");
        for (int a = 0; a < REGSZ; a += 15) begin
            write_burst(REGION + a, (REGSZ - a < 15) ? REGSZ - a : 15, 4'b1111, 1'b1, '0);
        end
        for (int i = 0; i < 60; i++) begin
            int op;
            int n;
            int bc;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                n = $urandom_range(1, 15);
                write_burst(REGION + $urandom_range(0, REGSZ - n), n, BE_W'($urandom), 1'b1, '0);
            end else if (op == 1) begin
                bc = $urandom_range(0, 15);
                n  = (bc == 0) ? 1 : bc;
                read_burst(REGION + $urandom_range(0, REGSZ - n), bc, "rand");
            end else begin
                next_cycle();
                check_output("rand_idle_rdv", DATA_W'(readdatavalid), '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
